// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the count_sched round-robin counter scheduler.
// Optional abort support is enabled by defining COUNT_SCHED_ABORT_EN.
package count_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } sched_state_t;

    // Round-robin successor of an owner index.
    function automatic int rr_next(input int id, input int nreq);
        return (id + 1 >= nreq) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// The pointer position itself has the highest priority.
module rr_arbiter
    import count_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    int pos;

    // Scan from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (req[IDW'(pos)]) begin
                grant            = '0;
                grant[IDW'(pos)] = 1'b1;
                grant_idx        = IDW'(pos);
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one loadable up-counter between NREQ requesters.
// Define COUNT_SCHED_ABORT_EN to add the abort input and aborted pulse output.
module count_sched
    import count_sched_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_start,
    input  logic [NREQ*WIDTH-1:0] req_term,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  cnt_load,
    output logic                  cnt_enable,
    output logic [WIDTH-1:0]      cnt_data,
    input  logic [WIDTH-1:0]      cnt_count
`ifdef COUNT_SCHED_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);

    sched_state_t     state_reg, state_next;
    logic [WIDTH-1:0] start_reg, term_reg;
    logic [IDW-1:0]   grant_id_reg;
    logic [IDW-1:0]   ptr_reg;

    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;

    logic             abort_act;
    logic             abort_hit;
    logic             job_active;

    logic [WIDTH-1:0] start_slice [NREQ];
    logic [WIDTH-1:0] term_slice  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign start_slice[gi] = req_start[gi*WIDTH +: WIDTH];
            assign term_slice[gi]  = req_term[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

`ifdef COUNT_SCHED_ABORT_EN
    logic aborted_reg;

    assign abort_act = abort;
    assign aborted   = aborted_reg;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= abort_hit;
        end
    end
`else
    assign abort_act = 1'b0;
`endif

    assign job_active = (state_reg == LOAD) || (state_reg == RUN);
    assign abort_hit  = abort_act && job_active;

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Job latches and round-robin pointer; the pointer moves past the owner
    // whether the job completes or is abandoned by abort.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            start_reg    <= '0;
            term_reg     <= '0;
            grant_id_reg <= '0;
            ptr_reg      <= '0;
        end else begin
            if (state_reg == IDLE && arb_any) begin
                start_reg    <= start_slice[arb_idx];
                term_reg     <= term_slice[arb_idx];
                grant_id_reg <= arb_idx;
            end
            if (state_reg == FIN || abort_hit) begin
                ptr_reg <= IDW'(rr_next(int'(grant_id_reg), NREQ));
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = abort_hit ? IDLE : RUN;
            end
            RUN: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (cnt_count == term_reg) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic; req_ready is masked by rst_ so nothing is offered while
    // reset is asserted even though the state already reads IDLE.
    always_comb begin
        req_ready  = '0;
        done       = '0;
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = arb_grant & {NREQ{rst_}};
            end
            LOAD: begin
                cnt_load = !abort_act;
            end
            RUN: begin
                cnt_enable = (cnt_count != term_reg) && !abort_act;
            end
            FIN: begin
                done[grant_id_reg] = 1'b1;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign grant_id = grant_id_reg;
    assign cnt_data = start_reg;

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched with a behavioural counter and reference model.
// Build with COUNT_SCHED_ABORT_EN defined to also exercise the abort path.
module tb_count_sched;

    localparam int NREQ = 4;
    localparam int W    = 5;

    logic              clk;
    logic              rst_;
    logic [NREQ-1:0]   req_valid;
    wire  [NREQ*W-1:0] req_start;
    wire  [NREQ*W-1:0] req_term;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [1:0]        grant_id;
    logic              cnt_load;
    logic              cnt_enable;
    logic [W-1:0]      cnt_data;
    logic [W-1:0]      cnt_count;
`ifdef COUNT_SCHED_ABORT_EN
    logic              abort;
    logic              aborted;
`endif

    logic [W-1:0] st [NREQ];
    logic [W-1:0] tm [NREQ];

    int n_cmp;
    int n_err;
    int ptr_m;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_start[gi*W +: W] = st[gi];
            assign req_term[gi*W +: W]  = tm[gi];
        end
    endgenerate

    count_sched #(
        .NREQ  (NREQ),
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .req_valid  (req_valid),
        .req_start  (req_start),
        .req_term   (req_term),
        .req_ready  (req_ready),
        .done       (done),
        .busy       (busy),
        .grant_id   (grant_id),
        .cnt_load   (cnt_load),
        .cnt_enable (cnt_enable),
        .cnt_data   (cnt_data),
        .cnt_count  (cnt_count)
`ifdef COUNT_SCHED_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted)
`endif
    );

    // The shared up-counter datapath the scheduler drives.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_count <= '0;
        end else if (cnt_load) begin
            cnt_count <= cnt_data;
        end else if (cnt_enable) begin
            cnt_count <= cnt_count + 5'd1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbitration rule: first valid index at or after p, wrapping.
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (((m >> idx) & 4'd1) != 4'd0) begin
                return idx;
            end
        end
        return -1;
    endfunction

    // One complete job from accept to the IDLE cycle after done.
    task automatic run_job(input logic [NREQ-1:0] mask, input logic drop, input bit scramble);
        int g;
        int n;
        logic [W-1:0] s;
        logic [W-1:0] t;
        logic [W-1:0] d;
        logic [W-1:0] e;
        req_valid = mask;
        #1;
        g = pick(mask, ptr_m);
        if (g < 0) begin
            n_cmp++; n_err++;
            $display("FAIL job_mask: empty request mask given to job");
            return;
        end
        s = st[g];
        t = tm[g];
        d = t - s;
        n = int'(d);
        n_cmp++;
        if (req_ready !== (4'b0001 << g) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL accept: ready=%b busy=%b want ready=%b busy=0", req_ready, busy, 4'b0001 << g);
        end
        @(posedge clk); #1;
        if (drop) req_valid[g] = 1'b0;
        if (scramble) begin
            st[g] = 5'($urandom);
            tm[g] = 5'($urandom);
        end
        #1;
        n_cmp++;
        if ({busy, cnt_load, cnt_enable, cnt_data, grant_id} !== {1'b1, 1'b1, 1'b0, s, 2'(g)}) begin
            n_err++;
            $display("FAIL load: busy=%b load=%b en=%b data=%0d gid=%0d want 1 1 0 %0d %0d",
                     busy, cnt_load, cnt_enable, cnt_data, grant_id, s, g);
        end
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            e = s + 5'(k);
            n_cmp++;
            if (cnt_count !== e || cnt_enable !== (k != n) || done !== 4'b0 ||
                req_ready !== 4'b0 || cnt_load !== 1'b0) begin
                n_err++;
                $display("FAIL run[%0d]: count=%0d en=%b done=%b ready=%b load=%b want count=%0d en=%b done=0 ready=0 load=0",
                         k, cnt_count, cnt_enable, done, req_ready, cnt_load, e, (k != n));
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== (4'b0001 << g) || cnt_enable !== 1'b0 || cnt_count !== t || busy !== 1'b1) begin
            n_err++;
            $display("FAIL fin: done=%b en=%b count=%0d busy=%b want done=%b en=0 count=%0d busy=1",
                     done, cnt_enable, cnt_count, busy, 4'b0001 << g, t);
        end
        ptr_m = (g + 1) % NREQ;
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 4'b0 || busy !== 1'b0 || cnt_count !== t) begin
            n_err++;
            $display("FAIL idle_after: done=%b busy=%b count=%0d want done=0 busy=0 count=%0d",
                     done, busy, cnt_count, t);
        end
        $display("job: mask=%b grant=%0d start=%0d term=%0d cycles_to_done=%0d", mask, g, s, t, n + 3);
    endtask

    task automatic test_reset();
        rst_      = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            st[i] = 5'(i + 1);
            tm[i] = 5'(i + 9);
        end
        @(posedge clk); @(posedge clk); #1;
        n_cmp++;
        if ({req_ready, done, busy, cnt_load, cnt_enable, cnt_data, grant_id} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b done=%b busy=%b load=%b en=%b data=%0d gid=%0d want all 0",
                     req_ready, done, busy, cnt_load, cnt_enable, cnt_data, grant_id);
        end
        req_valid = 4'b0;
        @(posedge clk); #1;
        rst_  = 1'b1;
        ptr_m = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 4'b0) begin
            n_err++;
            $display("FAIL idle_no_req: busy=%b ready=%b want 0 0", busy, req_ready);
        end
        $display("reset: checked outputs during and after reset");
    endtask

    task automatic test_single();
        st[0] = 5'd3; tm[0] = 5'd7;
        run_job(4'b0001, 1'b1, 1'b0);
    endtask

    task automatic test_equal();
        st[2] = 5'd10; tm[2] = 5'd10;
        run_job(4'b0100, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        st[3] = 5'd30; tm[3] = 5'd2;
        run_job(4'b1000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NREQ; i++) begin
            st[i] = 5'($urandom);
            tm[i] = st[i] + 5'($urandom_range(0, 6));
        end
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, 1'b0, 1'b1);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] m;
        int gap;
        for (int it = 0; it < 20; it++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                st[i] = 5'($urandom);
                tm[i] = 5'($urandom);
            end
            run_job(m, 1'($urandom_range(0, 1)), 1'b1);
            gap = $urandom_range(0, 2);
            req_valid = 4'b0;
            for (int c = 0; c < gap; c++) begin
                #1;
                n_cmp++;
                if (req_ready !== 4'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap: ready=%b busy=%b want 0 0", req_ready, busy);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_async_reset();
        st[2] = 5'd2; tm[2] = 5'd9;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = 4'b1010;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (cnt_count !== 5'd5 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: count=%0d busy=%b want 5 1", cnt_count, busy);
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, done, busy, cnt_load, cnt_enable, cnt_data, grant_id} !== 18'd0 || cnt_count !== 5'd0) begin
            n_err++;
            $display("FAIL async_reset: ready=%b done=%b busy=%b load=%b en=%b data=%0d gid=%0d count=%0d want all 0",
                     req_ready, done, busy, cnt_load, cnt_enable, cnt_data, grant_id, cnt_count);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 4'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: done=%b busy=%b want 0 0", done, busy);
        end
        rst_  = 1'b1;
        ptr_m = 0;
        $display("async_reset: job abandoned at count 5");
        st[1] = 5'd4; tm[1] = 5'd6;
        st[3] = 5'd0; tm[3] = 5'd1;
        run_job(4'b1010, 1'b1, 1'b0);
        run_job(4'b1000, 1'b1, 1'b0);
    endtask

`ifdef COUNT_SCHED_ABORT_EN
    task automatic test_abort();
        int g;
        g = pick(4'b0100, ptr_m);
        st[2] = 5'd2; tm[2] = 5'd9;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (cnt_count !== 5'd4 || cnt_enable !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort: count=%0d en=%b want 4 1", cnt_count, cnt_enable);
        end
        abort = 1'b1;
        #1;
        n_cmp++;
        if (cnt_enable !== 1'b0 || cnt_load !== 1'b0 || aborted !== 1'b0) begin
            n_err++;
            $display("FAIL abort_cycle: en=%b load=%b aborted=%b want 0 0 0", cnt_enable, cnt_load, aborted);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        ptr_m = (g + 1) % NREQ;
        n_cmp++;
        if (aborted !== 1'b1 || done !== 4'b0 || busy !== 1'b0 || cnt_count !== 5'd4) begin
            n_err++;
            $display("FAIL abort_after: aborted=%b done=%b busy=%b count=%0d want 1 0 0 4",
                     aborted, done, busy, cnt_count);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (aborted !== 1'b0) begin
            n_err++;
            $display("FAIL aborted_pulse: aborted=%b want 0", aborted);
        end
        $display("abort: job on req 2 abandoned at count 4");
        for (int i = 0; i < NREQ; i++) begin
            st[i] = 5'(i); tm[i] = 5'(i + 2);
        end
        run_job(4'b1111, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        ptr_m     = 0;
        req_valid = '0;
`ifdef COUNT_SCHED_ABORT_EN
        abort     = 1'b0;
`endif
        test_reset();
        test_single();
        test_equal();
        test_wrap();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef COUNT_SCHED_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
